// File: rtl/seq_reco_pkg.sv
// Shared types and constants for the multi-channel stochastic-stream recorrelator.
package seq_reco_pkg;
  typedef enum logic {RECO_POS = 1'b0, RECO_NEG = 1'b1} reco_mode_e;
  typedef enum logic {SIDE_Y = 1'b0, SIDE_X = 1'b1} side_e;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/seq_reco_multi_if.sv
// Sample/result bundle for seq_reco_multi; overflow signals exist only with SEQ_RECO_OVF_EN.
interface seq_reco_multi_if
  import seq_reco_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH + 1);

  logic                in_valid;
  logic [NCH-1:0]      x;
  logic [NCH-1:0]      y;
  logic [NCH-1:0]      mode;
  logic                out_valid;
  logic [NCH-1:0]      x_reco;
  logic [NCH-1:0]      y_reco;
  logic [NCH*LW-1:0]   depth_lvl;
`ifdef SEQ_RECO_OVF_EN
  logic                    ovf_clr;
  logic [NCH-1:0]          ovf_sticky;
  logic [NCH*DROP_CNT_W-1:0] drop_cnt;
`endif

  modport master (
    output in_valid, x, y, mode,
`ifdef SEQ_RECO_OVF_EN
    output ovf_clr,
    input  ovf_sticky, drop_cnt,
`endif
    input  out_valid, x_reco, y_reco, depth_lvl
  );

  modport slave (
    input  in_valid, x, y, mode,
`ifdef SEQ_RECO_OVF_EN
    input  ovf_clr,
    output ovf_sticky, drop_cnt,
`endif
    output out_valid, x_reco, y_reco, depth_lvl
  );
endinterface

// File: rtl/seq_reco_lane.sv
// One recorrelation channel: pairs unmatched X/Y ones up to DEPTH deep, result one cycle after a valid sample.
// No backpressure; in_valid=0 freezes the lane. Drop counting only with SEQ_RECO_OVF_EN.
module seq_reco_lane
  import seq_reco_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         x,
  input  logic                         y,
  input  logic                         mode,
`ifdef SEQ_RECO_OVF_EN
  input  logic                         ovf_clr,
  output logic                         ovf_sticky,
  output logic [DROP_CNT_W-1:0]        drop_cnt,
`endif
  output logic                         x_reco,
  output logic                         y_reco,
  output logic [$clog2(DEPTH+1)-1:0]   lvl
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam logic [SW-1:0] DMAX = SW'(DEPTH);

  logic [SW-1:0] state, st_eff, nst;
  side_e         sign, nsign;
  reco_mode_e    last_mode;
  logic          a, b, na, nb;
`ifdef SEQ_RECO_OVF_EN
  logic          drop;
`endif

  // Negative mode runs the positive rules on the inverted Y stream.
  always_comb begin
    a      = x;
    b      = y ^ mode;
    st_eff = (reco_mode_e'(mode) != last_mode) ? '0 : state;
    nst    = st_eff;
    nsign  = sign;
    na     = a;
    nb     = b;
`ifdef SEQ_RECO_OVF_EN
    drop   = 1'b0;
`endif
    if (a != b) begin
      if (st_eff == '0) begin
        na    = 1'b0;
        nb    = 1'b0;
        nst   = SW'(1);
        nsign = side_e'(a);
      end else if (side_e'(a) != sign) begin
        na  = 1'b1;
        nb  = 1'b1;
        nst = st_eff - 1'b1;
      end else if (st_eff < DMAX) begin
        na  = 1'b0;
        nb  = 1'b0;
        nst = st_eff + 1'b1;
      end else begin
`ifdef SEQ_RECO_OVF_EN
        drop = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      sign      <= SIDE_Y;
      last_mode <= RECO_POS;
      x_reco    <= 1'b0;
      y_reco    <= 1'b0;
    end else if (in_valid) begin
      state     <= nst;
      sign      <= nsign;
      last_mode <= reco_mode_e'(mode);
      x_reco    <= na;
      y_reco    <= nb ^ mode;
    end
  end

`ifdef SEQ_RECO_OVF_EN
  // Clear wins over a drop landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (in_valid && drop) begin
      ovf_sticky <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

  assign lvl = state;
endmodule

// File: rtl/seq_reco_multi.sv
// NCH independent recorrelation lanes; results and out_valid one cycle after the sample, no backpressure.
// Optional overflow/drop counters enabled by SEQ_RECO_OVF_EN.
module seq_reco_multi
  import seq_reco_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  seq_reco_multi_if.slave  io
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [NCH-1:0]    xr, yr;
  logic [NCH*LW-1:0] lvl;
`ifdef SEQ_RECO_OVF_EN
  logic [NCH-1:0]            stk;
  logic [NCH*DROP_CNT_W-1:0] dc;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    seq_reco_lane #(.DEPTH(DEPTH)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (io.in_valid),
      .x          (io.x[i]),
      .y          (io.y[i]),
      .mode       (io.mode[i]),
`ifdef SEQ_RECO_OVF_EN
      .ovf_clr    (io.ovf_clr),
      .ovf_sticky (stk[i]),
      .drop_cnt   (dc[i*DROP_CNT_W +: DROP_CNT_W]),
`endif
      .x_reco     (xr[i]),
      .y_reco     (yr[i]),
      .lvl        (lvl[i*LW +: LW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) io.out_valid <= 1'b0;
    else     io.out_valid <= io.in_valid;
  end

  assign io.x_reco    = xr;
  assign io.y_reco    = yr;
  assign io.depth_lvl = lvl;
`ifdef SEQ_RECO_OVF_EN
  assign io.ovf_sticky = stk;
  assign io.drop_cnt   = dc;
`endif
endmodule

// File: tb/tb_seq_reco_multi.sv
// Directed vector table plus randomized run against a behavioural model for seq_reco_multi (NCH=2, DEPTH=2).
module tb_seq_reco_multi;
  import seq_reco_pkg::*;
  localparam int NCH = 2, DEPTH = 2, LW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_reco_multi_if #(.NCH(NCH), .DEPTH(DEPTH)) io ();
  seq_reco_multi #(.NCH(NCH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io(io));

  int checks = 0, failures = 0;

  typedef struct {
    bit r; bit v; bit [1:0] x; bit [1:0] y; bit [1:0] m;
    bit [1:0] exr; bit [1:0] eyr; int el0; int el1; bit eov; int ed0; bit [1:0] estk;
  } vec_t;
  vec_t tbl[20];

  function automatic vec_t mk(bit r, bit v, bit [1:0] x, bit [1:0] y, bit [1:0] m,
                              bit [1:0] exr, bit [1:0] eyr, int el0, int el1, bit eov,
                              int ed0, bit [1:0] estk);
    vec_t t;
    t.r = r; t.v = v; t.x = x; t.y = y; t.m = m;
    t.exr = exr; t.eyr = eyr; t.el0 = el0; t.el1 = el1; t.eov = eov;
    t.ed0 = ed0; t.estk = estk;
    return t;
  endfunction

  task automatic check(string nm, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d required=%0d", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit v, bit [1:0] x, bit [1:0] y, bit [1:0] m, bit clr);
    rst = r; io.in_valid = v; io.x = x; io.y = y; io.mode = m;
`ifdef SEQ_RECO_OVF_EN
    io.ovf_clr = clr;
`else
    if (clr) ;
`endif
  endtask

  // Reference model: count of unmatched ones and which stream owes them.
  int       m_cnt[NCH];
  bit       m_side[NCH];
  bit       m_mode[NCH];
  bit [1:0] m_xr, m_yr;
  bit       m_ov;
  int       m_drop[NCH];
  bit [1:0] m_stk;

  function automatic void model(bit r, bit v, bit [1:0] x, bit [1:0] y, bit [1:0] m, bit clr);
    bit dropped[NCH];
    for (int c = 0; c < NCH; c++) dropped[c] = 0;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_side[c] = 0; m_mode[c] = 0;
      end
      m_xr = 0; m_yr = 0; m_ov = 0;
    end else begin
      m_ov = v;
      if (v) begin
        for (int c = 0; c < NCH; c++) begin
          bit a, b, oa, ob;
          if (m[c] != m_mode[c]) begin
            m_cnt[c] = 0;
            m_mode[c] = m[c];
          end
          a = x[c];
          b = y[c] ^ m[c];
          oa = a; ob = b;
          if (a != b) begin
            if (m_cnt[c] > 0 && a != m_side[c]) begin
              m_cnt[c]--; oa = 1; ob = 1;
            end else if (m_cnt[c] < DEPTH) begin
              if (m_cnt[c] == 0) m_side[c] = a;
              m_cnt[c]++; oa = 0; ob = 0;
            end else begin
              dropped[c] = 1;
            end
          end
          m_xr[c] = oa;
          m_yr[c] = ob ^ m[c];
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (r || clr) begin
        m_drop[c] = 0; m_stk[c] = 0;
      end else if (dropped[c]) begin
        m_stk[c] = 1;
        if (m_drop[c] < 65535) m_drop[c]++;
      end
    end
  endfunction

  task automatic check_model(int cyc);
    check("rnd_out_valid", cyc, int'(io.out_valid), int'(m_ov));
    check("rnd_x_reco", cyc, int'(io.x_reco), int'(m_xr));
    check("rnd_y_reco", cyc, int'(io.y_reco), int'(m_yr));
    for (int c = 0; c < NCH; c++)
      check("rnd_depth_lvl", cyc * 10 + c, int'(io.depth_lvl[c*LW +: LW]), m_cnt[c]);
`ifdef SEQ_RECO_OVF_EN
    check("rnd_ovf_sticky", cyc, int'(io.ovf_sticky), int'(m_stk));
    for (int c = 0; c < NCH; c++)
      check("rnd_drop_cnt", cyc * 10 + c, int'(io.drop_cnt[c*DROP_CNT_W +: DROP_CNT_W]), m_drop[c]);
`endif
  endtask

  bit [1:0] cur_mode;

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    //             r  v  x     y     m     exr   eyr   l0 l1 ov d0 stk
    tbl[0]  = mk(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
    tbl[1]  = mk(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 2'b00);
    tbl[2]  = mk(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 2'b00);
    tbl[3]  = mk(0, 1, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 0, 0, 1, 0, 2'b00);
    tbl[4]  = mk(0, 1, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 2'b00);
    tbl[5]  = mk(0, 1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0, 1, 0, 2'b00);
    tbl[6]  = mk(0, 1, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 1, 0, 1, 0, 2'b00);
    tbl[7]  = mk(0, 1, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2, 0, 1, 0, 2'b00);
    tbl[8]  = mk(0, 1, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2, 0, 1, 1, 2'b01);
    tbl[9]  = mk(0, 1, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 1, 0, 1, 1, 2'b01);
    tbl[10] = mk(0, 0, 2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 1, 0, 0, 1, 2'b01);
    tbl[11] = mk(0, 0, 2'b10, 2'b01, 2'b11, 2'b01, 2'b11, 1, 0, 0, 1, 2'b01);
    tbl[12] = mk(0, 0, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11, 1, 0, 0, 1, 2'b01);
    tbl[13] = mk(0, 1, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 0, 0, 1, 1, 2'b01);
    tbl[14] = mk(0, 1, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10, 1, 1, 1, 1, 2'b01);
    tbl[15] = mk(0, 1, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2, 1, 1, 1, 2'b01);
    tbl[16] = mk(0, 1, 2'b01, 2'b11, 2'b11, 2'b00, 2'b11, 1, 1, 1, 1, 2'b01);
    tbl[17] = mk(0, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2, 2, 1, 1, 2'b01);
    tbl[18] = mk(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
    tbl[19] = mk(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 2'b00);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].m, 0);
      step();
      check("vec_out_valid", i, int'(io.out_valid), int'(tbl[i].eov));
      check("vec_x_reco", i, int'(io.x_reco), int'(tbl[i].exr));
      check("vec_y_reco", i, int'(io.y_reco), int'(tbl[i].eyr));
      check("vec_lvl0", i, int'(io.depth_lvl[LW-1:0]), tbl[i].el0);
      check("vec_lvl1", i, int'(io.depth_lvl[2*LW-1:LW]), tbl[i].el1);
`ifdef SEQ_RECO_OVF_EN
      check("vec_drop0", i, int'(io.drop_cnt[DROP_CNT_W-1:0]), tbl[i].ed0);
      check("vec_sticky", i, int'(io.ovf_sticky), int'(tbl[i].estk));
`endif
    end

    // ch0 sits at state 1 owing X: fill, saturate, then clear on a dropping cycle.
    drive(0, 1, 2'b01, 2'b00, 2'b00, 0);
    step();
    check("seq_fill_lvl0", 0, int'(io.depth_lvl[LW-1:0]), 2);
    step();
    check("seq_sat_x", 0, int'(io.x_reco), 1);
    check("seq_sat_lvl0", 0, int'(io.depth_lvl[LW-1:0]), 2);
`ifdef SEQ_RECO_OVF_EN
    check("seq_sat_drop0", 0, int'(io.drop_cnt[DROP_CNT_W-1:0]), 1);
    check("seq_sat_sticky", 0, int'(io.ovf_sticky), 1);
    drive(0, 1, 2'b01, 2'b00, 2'b00, 1);
    step();
    check("seq_clr_drop0", 0, int'(io.drop_cnt[DROP_CNT_W-1:0]), 0);
    check("seq_clr_sticky", 0, int'(io.ovf_sticky), 0);
    drive(0, 1, 2'b01, 2'b00, 2'b00, 0);
    step();
    check("seq_after_clr_drop0", 0, int'(io.drop_cnt[DROP_CNT_W-1:0]), 1);
`endif

    // Randomized run against the model, including mid-stream resets and mode flips.
    drive(1, 0, 0, 0, 0, 0);
    model(1, 0, 0, 0, 0, 0);
    step();
    check_model(0);
    cur_mode = 2'b00;
    for (int cyc = 1; cyc <= 800; cyc++) begin
      bit r, v, clr;
      bit [1:0] rx, ry;
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 39) == 0);
      rx  = 2'($urandom_range(0, 3));
      ry  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) cur_mode = cur_mode ^ 2'($urandom_range(1, 3));
`ifndef SEQ_RECO_OVF_EN
      clr = 0;
`endif
      drive(r, v, rx, ry, cur_mode, clr);
      model(r, v, rx, ry, cur_mode, clr);
      step();
      check_model(cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_reco_multi.md
SEQ_RECO_MULTI -- requirements
Module: seq_reco_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent x/y channel pairs (NCH >= 1).
REQ-002 SHALL have parameter DEPTH, default 4, meaning maximum unmatched bits held per channel (DEPTH >= 1).
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the current x/y/mode sample is valid.
REQ-007 SHALL have port x, input, NCH bits: stochastic stream X, one bit per channel.
REQ-008 SHALL have port y, input, NCH bits: stochastic stream Y, one bit per channel.
REQ-009 SHALL have port mode, input, NCH bits: per channel, 0 = positive recorrelation, 1 = negative recorrelation.
REQ-010 SHALL have port out_valid, output, 1 bit: registered in_valid.
REQ-011 SHALL have port x_reco, output, NCH bits: recorrelated X, registered.
REQ-012 SHALL have port y_reco, output, NCH bits: recorrelated Y, registered.
REQ-013 SHALL have port depth_lvl, output, NCH x clog2(DEPTH+1) bits: current per-channel state count.

Function
REQ-014 Each channel SHALL hold a count state (0..DEPTH), a side flag sign (1 = X bit owed, 0 = Y bit owed) and the last applied mode.
REQ-015 In positive mode with inputs a=x, b=y, x==y SHALL pass a/b through unchanged with state and sign held.
REQ-016 In positive mode, a!=b with state==0 SHALL output 00, increment state, and set sign=a.
REQ-017 In positive mode, a!=b with state>0 and the incoming 1 on the side opposite sign SHALL output 11 and decrement state.
REQ-018 In positive mode, a!=b with the incoming 1 on the same side as sign SHALL, if state<DEPTH, output 00 and increment state; else (state==DEPTH, saturated) pass a/b through with state held.
REQ-019 Negative mode SHALL apply the positive-mode rules to a=x, b=~y and SHALL drive y_reco with the inverted b result.
REQ-020 Outputs SHALL appear on x_reco/y_reco exactly one clk after the input sample; out_valid SHALL equal in_valid delayed one cycle.
REQ-021 With in_valid=0, a channel SHALL hold state, sign and mode, and x_reco/y_reco SHALL hold their previous values.
REQ-022 With in_valid=1 and mode[i] differing from the last applied mode of channel i, that sample SHALL be processed in the new mode from state 0; stored bits SHALL be discarded.
REQ-023 Channels SHALL be fully independent; no cross-channel interaction.
REQ-024 depth_lvl SHALL reflect the registered state, i.e. the state after the last accepted sample.

Reset
REQ-025 rst=1 at a clk edge SHALL set every state=0, sign=0, last mode=0, x_reco=0, y_reco=0 and out_valid=0, and SHALL override in_valid, including mid-stream.

Configuration
REQ-026 With macro SEQ_RECO_OVF_EN defined, the module SHALL add input ovf_clr (1 bit), output ovf_sticky (NCH bits) and output drop_cnt (NCH x DROP_CNT_W bits).
REQ-027 Under SEQ_RECO_OVF_EN, each REQ-018 saturated pass-through SHALL increment drop_cnt[i], saturating at all-ones, and SHALL set ovf_sticky[i].
REQ-028 Under SEQ_RECO_OVF_EN, rst or ovf_clr SHALL zero drop_cnt and ovf_sticky, and ovf_clr SHALL take priority over a same-cycle increment.
REQ-029 Without SEQ_RECO_OVF_EN, these ports and counters SHALL NOT exist, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Package seq_reco_pkg SHALL define the mode enum (RECO_POS=0, RECO_NEG=1), the side enum (SIDE_Y=0, SIDE_X=1) and the constant DROP_CNT_W=16.
REQ-031 Per-channel logic SHALL be sub-module seq_reco_lane (parameter DEPTH), instantiated NCH times by a generate loop, and the top SHALL own only the out_valid register.

Verification (NCH=2, DEPTH=2 unless noted)
REQ-032 ch0 positive, valid x=1,0,0 and y=0,0,1 -> x_reco/y_reco one cycle later 00,00,11; depth_lvl 1,1,0.
REQ-033 ch0 positive, x=1/y=0 for three cycles -> outputs 00,00,10; depth_lvl 1,2,2; with SEQ_RECO_OVF_EN, drop_cnt[0]=1 and ovf_sticky[0]=1.
REQ-034 ch1 negative, x/y=11 then 00 -> outputs 01 then 10; depth_lvl 1 then 0.
REQ-035 ch0 holding state=1, in_valid=0 for 3 cycles -> out_valid=0, outputs and depth_lvl=1 unchanged; next valid x=0,y=1 -> 11.
REQ-036 ch0 at state=2, mode toggled 0->1 with x=1,y=1 -> output 01 and depth_lvl=1 (restarted from 0); ch1 unaffected.
REQ-037 rst asserted with both channels at state=2 -> next cycle all outputs 0 and depth_lvl 0; ovf_clr pulse -> drop_cnt and ovf_sticky zero.
